// File: rtl/ptr_seq.sv
// Sequencing controller for a 16-bit counting pointer register: LOAD, BURST and READ commands
// are turned into registered, glitch-free load/count/output-enable strobes and a memory handshake.
module ptr_seq #(
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [15:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             abort,
   output logic             mem_req,
   input  logic             mem_ack,
   output logic [7:0]       di_out,
   output logic             n_we_l,
   output logic             n_we_h,
   output logic             cnt,
   output logic             n_oe_addr,
   output logic             n_oe_dl,
   output logic             n_oe_dh,
   output logic             rd_valid,
   output logic             rd_hi,
   output logic             done,
   output logic             busy
);

   localparam logic [1:0] OpNop   = 2'd0;
   localparam logic [1:0] OpLoad  = 2'd1;
   localparam logic [1:0] OpBurst = 2'd2;
   localparam logic [1:0] OpRead  = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StLoadL,
      StLoadH,
      StAcc,
      StStep,
      StReadL,
      StReadH
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      addr_q, addr_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             done_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OpLoad: begin
                     addr_d  = cmd_addr;
                     state_d = StLoadL;
                  end
                  OpBurst: begin
                     if (cmd_len == '0) begin
                        done_d = 1'b1;
                     end else begin
                        rem_d   = cmd_len;
                        state_d = StAcc;
                     end
                  end
                  OpRead:  state_d = StReadL;
                  OpNop:   state_d = StIdle;
                  default: state_d = StIdle;
               endcase
            end
         end
         StLoadL: state_d = StLoadH;
         StLoadH: begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
         StAcc: begin
            // abort wins over a simultaneous ack: the access is dropped, pointer not advanced
            if (abort) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else if (mem_ack) begin
               state_d = StStep;
            end
         end
         StStep: begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               state_d = StAcc;
            end
         end
         StReadL: state_d = StReadH;
         StReadH: begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they track state_q exactly.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         rem_q     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_req   <= 1'b0;
         n_oe_addr <= 1'b1;
         cnt       <= 1'b0;
         n_we_l    <= 1'b1;
         n_we_h    <= 1'b1;
         n_oe_dl   <= 1'b1;
         n_oe_dh   <= 1'b1;
         rd_valid  <= 1'b0;
         rd_hi     <= 1'b0;
         di_out    <= 8'h00;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         cmd_ready <= (state_d == StIdle);
         busy      <= (state_d != StIdle);
         done      <= done_d;
         mem_req   <= (state_d == StAcc);
         n_oe_addr <= (state_d != StAcc);
         cnt       <= (state_d == StStep);
         n_we_l    <= (state_d != StLoadL);
         n_we_h    <= (state_d != StLoadH);
         n_oe_dl   <= (state_d != StReadL);
         n_oe_dh   <= (state_d != StReadH);
         rd_valid  <= (state_d == StReadL) || (state_d == StReadH);
         rd_hi     <= (state_d == StReadH);
         if (state_d == StLoadL) begin
            di_out <= addr_d[7:0];
         end else if (state_d == StLoadH) begin
            di_out <= addr_d[15:8];
         end else begin
            di_out <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_ptr_seq.sv
// Directed bench for ptr_seq: a behavioural pointer register and memory responder sit on the
// strobe side; each task drives one scenario and compares against hand-computed constants.
module tb_ptr_seq;

   logic        clk;
   logic        n_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        abort;
   logic        mem_req;
   logic        mem_ack;
   logic [7:0]  di_out;
   logic        n_we_l, n_we_h, cnt, n_oe_addr, n_oe_dl, n_oe_dh;
   logic        rd_valid, rd_hi, done, busy;

   ptr_seq #(.LEN_W(8)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .abort     (abort),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .di_out    (di_out),
      .n_we_l    (n_we_l),
      .n_we_h    (n_we_h),
      .cnt       (cnt),
      .n_oe_addr (n_oe_addr),
      .n_oe_dl   (n_oe_dl),
      .n_oe_dh   (n_oe_dh),
      .rd_valid  (rd_valid),
      .rd_hi     (rd_hi),
      .done      (done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Pointer register model, cleared by the same reset.
   logic [15:0] ptr;
   logic [7:0]  dbus;
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr <= 16'h0000;
      end else begin
         if (!n_we_l) ptr[7:0] <= di_out;
         if (!n_we_h) ptr[15:8] <= di_out;
         if (cnt) ptr <= ptr + 16'd1;
      end
   end
   always_comb dbus = !n_oe_dl ? ptr[7:0] : (!n_oe_dh ? ptr[15:8] : 8'h00);

   // Memory responder and bus monitor, evaluated at the falling edge.
   int          ack_delay = 0;
   int          abort_at  = 0;
   int          wcnt      = 0;
   int          n_acc     = 0;
   int          n_cnt     = 0;
   int          n_done    = 0;
   int          req_cycles = 0;
   logic        req_prev  = 1'b0;
   logic [15:0] addr_log [0:7];

   always @(negedge clk) begin
      if (mem_req) begin
         if (!req_prev) begin
            if (n_acc < 8) addr_log[n_acc] = ptr;
            n_acc = n_acc + 1;
            wcnt  = 0;
         end
         req_cycles = req_cycles + 1;
         mem_ack = (wcnt == ack_delay);
         abort   = (n_acc == abort_at);
         wcnt    = wcnt + 1;
      end else begin
         mem_ack = 1'b0;
         abort   = 1'b0;
      end
      if (cnt) n_cnt = n_cnt + 1;
      if (done) n_done = n_done + 1;
      req_prev = mem_req;
      n_checks = n_checks + 3;
      if (!n_oe_dl && !n_oe_dh) begin
         n_fail = n_fail + 1;
         $display("FAIL inv_oe_data: n_oe_dl=%b n_oe_dh=%b, required not both 0", n_oe_dl, n_oe_dh);
      end
      if (!n_oe_addr && (!n_we_l || !n_we_h)) begin
         n_fail = n_fail + 1;
         $display("FAIL inv_oe_addr_we: n_oe_addr=%b n_we_l=%b n_we_h=%b", n_oe_addr, n_we_l, n_we_h);
      end
      if (cnt && (!n_we_l || !n_we_h)) begin
         n_fail = n_fail + 1;
         $display("FAIL inv_cnt_we: cnt=%b n_we_l=%b n_we_h=%b", cnt, n_we_l, n_we_h);
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon;
      n_acc      = 0;
      n_cnt      = 0;
      n_done     = 0;
      req_cycles = 0;
   endtask

   // Present one command for one edge, then scramble the operands to prove they were latched.
   task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_addr  = 16'hDEAD;
      cmd_len   = 8'hFF;
   endtask

   task automatic wait_done(input int bound, input string name);
      int k = 0;
      while (!done && k < bound) begin
         tick();
         k++;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, bound);
      end
   endtask

   task automatic test_reset;
      n_rst = 1'b0;
      repeat (2) tick();
      n_checks++;
      if ({cmd_ready, busy, done, mem_req, cnt, rd_valid, rd_hi} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b, required 1000000",
                  {cmd_ready, busy, done, mem_req, cnt, rd_valid, rd_hi});
      end
      n_checks++;
      if ({n_we_l, n_we_h, n_oe_addr, n_oe_dl, n_oe_dh} !== 5'b11111 || di_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_strobes: n_*=%b di_out=%h, required 11111 00",
                  {n_we_l, n_we_h, n_oe_addr, n_oe_dl, n_oe_dh}, di_out);
      end
      n_rst = 1'b1;
      tick();
   endtask

   task automatic test_nop_and_load;
      clear_mon();
      issue(2'd0, 16'h5555, 8'd0);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL nop: busy=%b done=%b, required 0 0", busy, done);
      end
      issue(2'd1, 16'h12AB, 8'd0);
      n_checks++;
      if (n_we_l !== 1'b0 || n_we_h !== 1'b1 || di_out !== 8'hAB || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL load_lo: n_we_l=%b n_we_h=%b di_out=%h ready=%b, required 0 1 ab 0",
                  n_we_l, n_we_h, di_out, cmd_ready);
      end
      tick();
      n_checks++;
      if (n_we_h !== 1'b0 || n_we_l !== 1'b1 || di_out !== 8'h12) begin
         n_fail++;
         $display("FAIL load_hi: n_we_h=%b n_we_l=%b di_out=%h, required 0 1 12",
                  n_we_h, n_we_l, di_out);
      end
      tick();
      n_checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b1 || ptr !== 16'h12AB) begin
         n_fail++;
         $display("FAIL load_done: done=%b ready=%b ptr=%h, required 1 1 12ab", done, cmd_ready, ptr);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || n_done !== 1) begin
         n_fail++;
         $display("FAIL load_done_pulse: done=%b count=%0d, required 0 1", done, n_done);
      end
   endtask

   task automatic test_burst;
      ack_delay = 0;
      issue(2'd1, 16'h12AB, 8'd0);
      wait_done(10, "burst_load");
      clear_mon();
      issue(2'd2, 16'h0000, 8'd3);
      wait_done(40, "burst");
      n_checks++;
      if (n_cnt !== 3 || n_acc !== 3 || req_cycles !== 3 || n_done !== 1) begin
         n_fail++;
         $display("FAIL burst_counts: cnt=%0d acc=%0d req=%0d done=%0d, required 3 3 3 1",
                  n_cnt, n_acc, req_cycles, n_done);
      end
      n_checks++;
      if (addr_log[0] !== 16'h12AB || addr_log[1] !== 16'h12AC || addr_log[2] !== 16'h12AD) begin
         n_fail++;
         $display("FAIL burst_addrs: %h %h %h, required 12ab 12ac 12ad",
                  addr_log[0], addr_log[1], addr_log[2]);
      end
      n_checks++;
      if (ptr !== 16'h12AE) begin
         n_fail++;
         $display("FAIL burst_ptr: ptr=%h, required 12ae", ptr);
      end
   endtask

   task automatic test_burst_wait;
      ack_delay = 2;
      issue(2'd1, 16'hFFFE, 8'd0);
      wait_done(10, "wait_load");
      clear_mon();
      issue(2'd2, 16'h0000, 8'd3);
      wait_done(60, "wait_burst");
      n_checks++;
      if (n_cnt !== 3 || req_cycles !== 9 || n_done !== 1) begin
         n_fail++;
         $display("FAIL wait_counts: cnt=%0d req=%0d done=%0d, required 3 9 1",
                  n_cnt, req_cycles, n_done);
      end
      n_checks++;
      if (addr_log[0] !== 16'hFFFE || addr_log[1] !== 16'hFFFF || addr_log[2] !== 16'h0000) begin
         n_fail++;
         $display("FAIL wait_addrs: %h %h %h, required fffe ffff 0000",
                  addr_log[0], addr_log[1], addr_log[2]);
      end
      n_checks++;
      if (ptr !== 16'h0001) begin
         n_fail++;
         $display("FAIL wait_ptr: ptr=%h, required 0001", ptr);
      end
      ack_delay = 0;
   endtask

   task automatic test_back_to_back_read;
      issue(2'd1, 16'h3C5A, 8'd0);
      wait_done(10, "read_load");
      issue(2'd3, 16'h0000, 8'd0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_hi !== 1'b0 || dbus !== 8'h5A || n_oe_dl !== 1'b0) begin
         n_fail++;
         $display("FAIL read_lo: rd_valid=%b rd_hi=%b bus=%h, required 1 0 5a", rd_valid, rd_hi, dbus);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_hi !== 1'b1 || dbus !== 8'h3C || n_oe_dh !== 1'b0) begin
         n_fail++;
         $display("FAIL read_hi: rd_valid=%b rd_hi=%b bus=%h, required 1 1 3c", rd_valid, rd_hi, dbus);
      end
      tick();
      n_checks++;
      if (done !== 1'b1 || rd_valid !== 1'b0 || n_oe_dh !== 1'b1) begin
         n_fail++;
         $display("FAIL read_done: done=%b rd_valid=%b n_oe_dh=%b, required 1 0 1",
                  done, rd_valid, n_oe_dh);
      end
   endtask

   task automatic test_zero_and_abort;
      clear_mon();
      issue(2'd2, 16'h0000, 8'd0);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len: done=%b busy=%b mem_req=%b, required 1 0 0", done, busy, mem_req);
      end
      tick();
      n_checks++;
      if (n_cnt !== 0 || req_cycles !== 0) begin
         n_fail++;
         $display("FAIL zero_len_strobes: cnt=%0d req=%0d, required 0 0", n_cnt, req_cycles);
      end
      issue(2'd1, 16'h4000, 8'd0);
      wait_done(10, "abort_load");
      clear_mon();
      abort_at = 2;
      issue(2'd2, 16'h0000, 8'd5);
      wait_done(40, "abort");
      n_checks++;
      if (n_cnt !== 1 || n_acc !== 2 || n_done !== 1 || ptr !== 16'h4001) begin
         n_fail++;
         $display("FAIL abort: cnt=%0d acc=%0d done=%0d ptr=%h, required 1 2 1 4001",
                  n_cnt, n_acc, n_done, ptr);
      end
      abort_at = 0;
      tick();
   endtask

   task automatic test_reset_mid;
      issue(2'd1, 16'h1000, 8'd0);
      wait_done(10, "rst_load");
      ack_delay = 100;
      issue(2'd2, 16'h0000, 8'd4);
      tick();
      n_checks++;
      if (mem_req !== 1'b1 || n_oe_addr !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait: mem_req=%b n_oe_addr=%b, required 1 0", mem_req, n_oe_addr);
      end
      n_rst = 1'b0;
      #1;
      n_checks++;
      if ({cmd_ready, busy, mem_req, cnt, done, n_oe_addr} !== 6'b100001) begin
         n_fail++;
         $display("FAIL rst_async: got %b, required 100001",
                  {cmd_ready, busy, mem_req, cnt, done, n_oe_addr});
      end
      tick();
      n_rst = 1'b1;
      ack_delay = 0;
      issue(2'd1, 16'h2468, 8'd0);
      wait_done(10, "rst_reload");
      n_checks++;
      if (ptr !== 16'h2468) begin
         n_fail++;
         $display("FAIL rst_reload: ptr=%h, required 2468", ptr);
      end
      clear_mon();
      issue(2'd2, 16'h0000, 8'd2);
      wait_done(20, "rst_burst");
      n_checks++;
      if (ptr !== 16'h246A || n_cnt !== 2) begin
         n_fail++;
         $display("FAIL rst_burst: ptr=%h cnt=%0d, required 246a 2", ptr, n_cnt);
      end
   endtask

   initial begin
      n_rst     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_addr  = 16'h0000;
      cmd_len   = 8'd0;
      mem_ack   = 1'b0;
      abort     = 1'b0;
      test_reset();
      test_nop_and_load();
      test_burst();
      test_burst_wait();
      test_back_to_back_read();
      test_zero_and_abort();
      test_reset_mid();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
